// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ready port and feeds IF/ID.
// Optional fetch/squash performance counters are enabled with `define IF_FETCH_PERF_EN.
module if_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        uncond_br,
    input  logic [63:0] br_pc,
    input  logic [18:0] condAddr19,
    input  logic [25:0] brAddr26,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] pc_plus4,
`ifdef IF_FETCH_PERF_EN
    output logic [31:0] fetch_count,
    output logic [31:0] squash_count,
`endif
    output logic        fetch_valid
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;
    logic [ILEN-1:0]   hold_q, hold_d;
    logic [ILEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pp4_q, pp4_d;
    logic              fv_q, fv_d;
    logic              req_q, req_d;
    logic [XLEN-1:0]   br_target;
    logic [XLEN-1:0]   pc_inc;

    // Word offset sign-extended to 62 bits, then scaled to a byte offset.
    assign br_target = br_pc + (uncond_br ? {{36{brAddr26[25]}}, brAddr26, 2'b00}
                                          : {{43{condAddr19[18]}}, condAddr19, 2'b00});
    assign pc_inc    = pc_q + XLEN'(4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                if (br_taken)                  state_d = imem_ready ? FETCH : DRAIN;
                else if (imem_ready && stall)  state_d = HOLD;
            end
            DRAIN: if (imem_ready)             state_d = FETCH;
            HOLD:  if (br_taken || !stall)     state_d = FETCH;
            default:                           state_d = IDLE;
        endcase
    end

    // Datapath next values; a redirect always forces a bubble regardless of stall.
    always_comb begin
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        hold_d  = hold_q;
        instr_d = instr_q;
        pp4_d   = pp4_q;
        fv_d    = fv_q;
        case (state_q)
            IDLE: if (br_taken) pc_d = br_target;
            FETCH: begin
                if (br_taken) begin
                    if (imem_ready) pc_d  = br_target;
                    else            tgt_d = br_target;
                end else if (imem_ready && !stall) begin
                    instr_d = imem_rdata;
                    pp4_d   = pc_inc;
                    fv_d    = 1'b1;
                    pc_d    = pc_inc;
                end else if (imem_ready && stall) begin
                    hold_d = imem_rdata;
                end else if (!stall) begin
                    instr_d = NOP_INSTR;
                    fv_d    = 1'b0;
                end
            end
            DRAIN: begin
                if (imem_ready)    pc_d  = br_taken ? br_target : tgt_q;
                else if (br_taken) tgt_d = br_target;
            end
            HOLD: begin
                if (br_taken) begin
                    pc_d = br_target;
                end else if (!stall) begin
                    instr_d = hold_q;
                    pp4_d   = pc_inc;
                    fv_d    = 1'b1;
                    pc_d    = pc_inc;
                end
            end
            default: pc_d = pc_q;
        endcase
        if (br_taken) begin
            instr_d = NOP_INSTR;
            fv_d    = 1'b0;
        end
        req_d = (state_d == FETCH) || (state_d == DRAIN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            tgt_q   <= '0;
            hold_q  <= '0;
            instr_q <= NOP_INSTR;
            pp4_q   <= '0;
            fv_q    <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pp4_q   <= pp4_d;
            fv_q    <= fv_d;
            req_q   <= req_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign pc_plus4    = pp4_q;
    assign fetch_valid = fv_q;

`ifdef IF_FETCH_PERF_EN
    logic        deliver;
    logic        squash;
    logic [31:0] fcnt_q, scnt_q;

    assign deliver = !br_taken && !stall &&
                     ((state_q == FETCH && imem_ready) || state_q == HOLD);
    assign squash  = (state_q == DRAIN && imem_ready) ||
                     (br_taken && ((state_q == FETCH && imem_ready) || state_q == HOLD));

    // Saturating event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            if (deliver && fcnt_q != 32'hFFFF_FFFF) fcnt_q <= fcnt_q + 32'd1;
            if (squash  && scnt_q != 32'hFFFF_FFFF) scnt_q <= scnt_q + 32'd1;
        end
    end

    assign fetch_count  = fcnt_q;
    assign squash_count = scnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: reset, streaming, wait states, stall/HOLD, redirects, PC wrap.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk, reset, stall, br_taken, uncond_br;
    logic [63:0] br_pc;
    logic [18:0] condAddr19;
    logic [25:0] brAddr26;
    logic        imem_req, imem_ready, fetch_valid;
    logic [63:0] imem_addr, pc_plus4;
    logic [31:0] imem_rdata, instruction;
`ifdef IF_FETCH_PERF_EN
    logic [31:0] fetch_count, squash_count;
`endif

    int errors = 0;
    int checks = 0;

    if_fetch_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .uncond_br(uncond_br),
        .br_pc(br_pc), .condAddr19(condAddr19), .brAddr26(brAddr26),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instruction(instruction), .pc_plus4(pc_plus4),
`ifdef IF_FETCH_PERF_EN
        .fetch_count(fetch_count), .squash_count(squash_count),
`endif
        .fetch_valid(fetch_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL rst_req: got %b want 0", imem_req); end
        checks++; if (imem_addr !== 64'd0)   begin errors++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        checks++; if (instruction !== NOP)   begin errors++; $display("FAIL rst_instr: got %h want %h", instruction, NOP); end
        checks++; if (pc_plus4 !== 64'd0)    begin errors++; $display("FAIL rst_pp4: got %h want 0", pc_plus4); end
        checks++; if (fetch_valid !== 1'b0)  begin errors++; $display("FAIL rst_fv: got %b want 0", fetch_valid); end
    endtask

    task automatic test_sequential();
        reset = 1'b1;
        tick();
        checks++; if (imem_req !== 1'b1)     begin errors++; $display("FAIL seq_req0: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 64'd0)   begin errors++; $display("FAIL seq_addr0: got %h want 0", imem_addr); end
        checks++; if (fetch_valid !== 1'b0)  begin errors++; $display("FAIL seq_fv0: got %b want 0", fetch_valid); end
        tick();
        checks++; if (instruction !== 32'hF8405087) begin errors++; $display("FAIL seq_instr: got %h want F8405087", instruction); end
        checks++; if (pc_plus4 !== 64'd4)    begin errors++; $display("FAIL seq_pp4: got %h want 4", pc_plus4); end
        checks++; if (fetch_valid !== 1'b1)  begin errors++; $display("FAIL seq_fv: got %b want 1", fetch_valid); end
        checks++; if (imem_addr !== 64'd4)   begin errors++; $display("FAIL seq_addr4: got %h want 4", imem_addr); end
        tick();
        checks++; if (imem_addr !== 64'd8)   begin errors++; $display("FAIL seq_addr8: got %h want 8", imem_addr); end
        checks++; if (pc_plus4 !== 64'd8)    begin errors++; $display("FAIL seq_pp4_8: got %h want 8", pc_plus4); end
    endtask

    task automatic test_wait_states();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (imem_req !== 1'b1)    begin errors++; $display("FAIL wait_req[%0d]: got %b want 1", i, imem_req); end
            checks++; if (imem_addr !== 64'd8)  begin errors++; $display("FAIL wait_addr[%0d]: got %h want 8", i, imem_addr); end
            checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL wait_fv[%0d]: got %b want 0", i, fetch_valid); end
            checks++; if (instruction !== NOP)  begin errors++; $display("FAIL wait_instr[%0d]: got %h want %h", i, instruction, NOP); end
        end
        imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        checks++; if (instruction !== 32'h1111_1111) begin errors++; $display("FAIL wait_word: got %h want 11111111", instruction); end
        checks++; if (pc_plus4 !== 64'd12)   begin errors++; $display("FAIL wait_pp4: got %h want c", pc_plus4); end
        checks++; if (fetch_valid !== 1'b1)  begin errors++; $display("FAIL wait_fv: got %b want 1", fetch_valid); end
        checks++; if (imem_addr !== 64'd12)  begin errors++; $display("FAIL wait_addr: got %h want c", imem_addr); end
    endtask

    task automatic test_stall_hold();
        imem_rdata = 32'h2222_2222;
        tick();
        checks++; if (imem_addr !== 64'd16)  begin errors++; $display("FAIL st_addr16: got %h want 10", imem_addr); end
        stall = 1'b1; imem_rdata = 32'h3333_3333;
        tick();
        checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL st_req0: got %b want 0", imem_req); end
        checks++; if (instruction !== 32'h2222_2222) begin errors++; $display("FAIL st_instr0: got %h want 22222222", instruction); end
        checks++; if (pc_plus4 !== 64'd16)   begin errors++; $display("FAIL st_pp4_0: got %h want 10", pc_plus4); end
        checks++; if (fetch_valid !== 1'b1)  begin errors++; $display("FAIL st_fv0: got %b want 1", fetch_valid); end
        imem_ready = 1'b0;
        tick();
        checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL st_req1: got %b want 0", imem_req); end
        checks++; if (instruction !== 32'h2222_2222) begin errors++; $display("FAIL st_instr1: got %h want 22222222", instruction); end
        stall = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h4444_4444;
        tick();
        checks++; if (instruction !== 32'h3333_3333) begin errors++; $display("FAIL st_rel_instr: got %h want 33333333", instruction); end
        checks++; if (pc_plus4 !== 64'd20)   begin errors++; $display("FAIL st_rel_pp4: got %h want 14", pc_plus4); end
        checks++; if (fetch_valid !== 1'b1)  begin errors++; $display("FAIL st_rel_fv: got %b want 1", fetch_valid); end
        checks++; if (imem_addr !== 64'd20)  begin errors++; $display("FAIL st_rel_addr: got %h want 14", imem_addr); end
        checks++; if (imem_req !== 1'b1)     begin errors++; $display("FAIL st_rel_req: got %b want 1", imem_req); end
    endtask

    task automatic test_redirect_drain();
        imem_ready = 1'b0; br_taken = 1'b1; uncond_br = 1'b0; br_pc = 64'd100; condAddr19 = 19'h7FFFE;
        tick();
        checks++; if (fetch_valid !== 1'b0)  begin errors++; $display("FAIL dr_fv: got %b want 0", fetch_valid); end
        checks++; if (instruction !== NOP)   begin errors++; $display("FAIL dr_instr: got %h want %h", instruction, NOP); end
        checks++; if (imem_addr !== 64'd20)  begin errors++; $display("FAIL dr_addr_old: got %h want 14", imem_addr); end
        checks++; if (imem_req !== 1'b1)     begin errors++; $display("FAIL dr_req: got %b want 1", imem_req); end
        checks++; if (pc_plus4 !== 64'd20)   begin errors++; $display("FAIL dr_pp4: got %h want 14", pc_plus4); end
        br_taken = 1'b0;
        tick();
        checks++; if (imem_addr !== 64'd20)  begin errors++; $display("FAIL dr_addr_hold: got %h want 14", imem_addr); end
        imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++; if (imem_addr !== 64'd92)  begin errors++; $display("FAIL dr_target: got %h want 5c", imem_addr); end
        checks++; if (instruction !== NOP)   begin errors++; $display("FAIL dr_discard: got %h want %h", instruction, NOP); end
        checks++; if (fetch_valid !== 1'b0)  begin errors++; $display("FAIL dr_fv_after: got %b want 0", fetch_valid); end
        imem_rdata = 32'h5555_5555;
        tick();
        checks++; if (instruction !== 32'h5555_5555) begin errors++; $display("FAIL dr_next_instr: got %h want 55555555", instruction); end
        checks++; if (pc_plus4 !== 64'd96)   begin errors++; $display("FAIL dr_next_pp4: got %h want 60", pc_plus4); end
    endtask

    task automatic test_redirect_stall();
        br_taken = 1'b1; uncond_br = 1'b1; br_pc = 64'd0; brAddr26 = 26'd10; stall = 1'b1; imem_rdata = 32'h6666_6666;
        tick();
        checks++; if (fetch_valid !== 1'b0)  begin errors++; $display("FAIL rs_fv: got %b want 0", fetch_valid); end
        checks++; if (instruction !== NOP)   begin errors++; $display("FAIL rs_instr: got %h want %h", instruction, NOP); end
        checks++; if (imem_addr !== 64'd40)  begin errors++; $display("FAIL rs_addr: got %h want 28", imem_addr); end
        checks++; if (pc_plus4 !== 64'd96)   begin errors++; $display("FAIL rs_pp4: got %h want 60", pc_plus4); end
        br_taken = 1'b0; stall = 1'b0;
        tick();
        checks++; if (instruction !== 32'h6666_6666) begin errors++; $display("FAIL rs_next_instr: got %h want 66666666", instruction); end
        checks++; if (pc_plus4 !== 64'd44)   begin errors++; $display("FAIL rs_next_pp4: got %h want 2c", pc_plus4); end
    endtask

    task automatic test_redirect_hold();
        stall = 1'b1; imem_rdata = 32'h7777_7777;
        tick();
        checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL rh_req_hold: got %b want 0", imem_req); end
        br_taken = 1'b1; uncond_br = 1'b0; br_pc = 64'h1000; condAddr19 = 19'd1;
        tick();
        checks++; if (imem_req !== 1'b1)     begin errors++; $display("FAIL rh_req: got %b want 1", imem_req); end
        checks++; if (imem_addr !== 64'h1004) begin errors++; $display("FAIL rh_addr: got %h want 1004", imem_addr); end
        checks++; if (fetch_valid !== 1'b0)  begin errors++; $display("FAIL rh_fv: got %b want 0", fetch_valid); end
        br_taken = 1'b0; stall = 1'b0; imem_rdata = 32'h8888_8888;
        tick();
        checks++; if (instruction !== 32'h8888_8888) begin errors++; $display("FAIL rh_instr: got %h want 88888888", instruction); end
        checks++; if (pc_plus4 !== 64'h1008) begin errors++; $display("FAIL rh_pp4: got %h want 1008", pc_plus4); end
    endtask

    task automatic test_pc_wrap();
        br_taken = 1'b1; uncond_br = 1'b1; br_pc = 64'd0; brAddr26 = 26'h3FF_FFFF;
        tick();
        checks++; if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffffffffffc", imem_addr); end
        br_taken = 1'b0; imem_rdata = 32'h9999_9999;
        tick();
        checks++; if (pc_plus4 !== 64'd0)    begin errors++; $display("FAIL wrap_pp4: got %h want 0", pc_plus4); end
        checks++; if (imem_addr !== 64'd0)   begin errors++; $display("FAIL wrap_next: got %h want 0", imem_addr); end
        checks++; if (instruction !== 32'h9999_9999) begin errors++; $display("FAIL wrap_instr: got %h want 99999999", instruction); end
    endtask

    task automatic test_reset_mid_drain();
        imem_ready = 1'b0; br_taken = 1'b1; uncond_br = 1'b0; br_pc = 64'd200; condAddr19 = 19'd4;
        tick();
        checks++; if (imem_req !== 1'b1)     begin errors++; $display("FAIL rmd_req_pre: got %b want 1", imem_req); end
        br_taken = 1'b0;
        #2 reset = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0)     begin errors++; $display("FAIL rmd_req: got %b want 0", imem_req); end
        checks++; if (fetch_valid !== 1'b0)  begin errors++; $display("FAIL rmd_fv: got %b want 0", fetch_valid); end
        checks++; if (instruction !== NOP)   begin errors++; $display("FAIL rmd_instr: got %h want %h", instruction, NOP); end
        checks++; if (imem_addr !== 64'd0)   begin errors++; $display("FAIL rmd_addr: got %h want 0", imem_addr); end
        tick();
        reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hABCD_0123;
        tick();
        checks++; if (imem_addr !== 64'd0)   begin errors++; $display("FAIL rmd_restart: got %h want 0", imem_addr); end
        checks++; if (fetch_valid !== 1'b0)  begin errors++; $display("FAIL rmd_idle_fv: got %b want 0", fetch_valid); end
        tick();
        checks++; if (instruction !== 32'hABCD_0123) begin errors++; $display("FAIL rmd_instr2: got %h want abcd0123", instruction); end
        checks++; if (pc_plus4 !== 64'd4)    begin errors++; $display("FAIL rmd_pp4: got %h want 4", pc_plus4); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; uncond_br = 1'b0;
        br_pc = '0; condAddr19 = '0; brAddr26 = '0;
        imem_ready = 1'b1; imem_rdata = 32'hF840_5087;
        #1 reset = 1'b0;
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_stall();
        test_redirect_hold();
        test_pc_wrap();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
